// File: rtl/inst_encoder_pkg.sv
// Shared RV32 encoder definitions: opcode constants, format codes, immediate limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   fmt_t      - instruction format selector driven on the encoder FMT port
//   OP_*       - major opcodes used by the program loader and benches
//   IMM*_MIN/MAX, SHAMT_MAX - immediate range limits per format
//   enc_fields_t - one set of decoded fields as captured by the first stage
package inst_encoder_pkg;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Format selector. Code 7 is deliberately left undefined.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_I_SH = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_t;

  // Immediate range limits (inclusive).
  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed SHAMT_MAX = 31;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4094;
  localparam int signed IMM21_MIN = -(1 << 20);
  localparam int signed IMM21_MAX = (1 << 20) - 2;

  // Decoded fields held in the first pipeline stage. fmt stays a raw
  // 3-bit code so that the undefined code can be carried and flagged.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/inst_encoder_imm_range_check.sv
// Flags an immediate that cannot be represented in the selected instruction format.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   fmt     in  3  - format code (fmt_t values, 7 = undefined)
//   imm     in  32 - signed immediate, or shift amount for FMT_I_SH
//   imm_err out 1  - 1 when imm is out of range / misaligned for fmt
module imm_range_check
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        imm_err
);

  logic signed [31:0] simm;
  logic               in_imm12;
  logic               in_shamt;
  logic               in_imm13;
  logic               in_imm21;
  logic               even;
  logic               u_aligned;

  assign simm      = $signed(imm);
  assign in_imm12  = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
  assign in_shamt  = (simm >= 0) && (simm <= SHAMT_MAX);
  assign in_imm13  = (simm >= IMM13_MIN) && (simm <= IMM13_MAX);
  assign in_imm21  = (simm >= IMM21_MIN) && (simm <= IMM21_MAX);
  // Branch and jump offsets are in halfwords: bit 0 is never encoded.
  assign even      = ~imm[0];
  // LUI/AUIPC only carry the upper 20 bits; any low bit would be lost.
  assign u_aligned = (imm[11:0] == 12'h000);

  always_comb begin
    imm_err = 1'b1;
    case (fmt)
      FMT_R:        imm_err = 1'b0;
      FMT_I, FMT_S: imm_err = ~in_imm12;
      FMT_I_SH:     imm_err = ~in_shamt;
      FMT_B:        imm_err = ~(in_imm13 & even);
      FMT_U:        imm_err = ~u_aligned;
      FMT_J:        imm_err = ~(in_imm21 & even);
      default:      imm_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32 instruction encoder: packs decoded fields + immediate into a word with its address.
// Latency: input handshake at edge N -> OUT_VALID after edge N+1 when the output stage is free.
// Backpressure: OUT holds while OUT_READY=0; S1 buffers one more word, then IN_READY drops.
//
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   IN_VALID/IN_READY   - input handshake (IN_READY is combinational)
//   FMT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM - decoded fields
//   OUT_VALID/OUT_READY - output handshake
//   INST, ADDR, IMM_ERR - encoded word, its word address, range-violation flag
//   ERR_SEEN            - sticky OR of IMM_ERR over every output handshake
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        FMT,
  input  logic [6:0]        OPCODE,
  input  logic [4:0]        RD,
  input  logic [4:0]        RS1,
  input  logic [4:0]        RS2,
  input  logic [2:0]        FUNCT3,
  input  logic [6:0]        FUNCT7,
  input  logic [31:0]       IMM,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       INST,
  output logic [ADDR_W-1:0] ADDR,
  output logic              IMM_ERR,
  output logic              ERR_SEEN
);

  enc_fields_t in_fields;
  enc_fields_t s1_q;
  logic        s1_vld;
  logic        s1_adv;
  logic        in_hs;
  logic        out_hs;
  logic [31:0] pack_inst;
  logic        range_err;

  assign in_fields = '{
    fmt:    FMT,
    opcode: OPCODE,
    rd:     RD,
    rs1:    RS1,
    rs2:    RS2,
    funct3: FUNCT3,
    funct7: FUNCT7,
    imm:    IMM
  };

  // S1 moves into OUT whenever OUT is empty or is being drained this cycle,
  // so a simultaneous pop and reload keeps the stream bubble-free.
  assign s1_adv   = s1_vld & (~OUT_VALID | OUT_READY);
  assign IN_READY = ~s1_vld | s1_adv;
  assign in_hs    = IN_VALID & IN_READY;
  assign out_hs   = OUT_VALID & OUT_READY;

  imm_range_check u_range (
    .fmt     (s1_q.fmt),
    .imm     (s1_q.imm),
    .imm_err (range_err)
  );

  // Packing mux. Out-of-range immediates are still packed from their
  // truncated bits; only the undefined format code yields an all-zero word.
  always_comb begin
    pack_inst = '0;
    case (s1_q.fmt)
      FMT_R:    pack_inst = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3,
                             s1_q.rd, s1_q.opcode};
      FMT_I:    pack_inst = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3,
                             s1_q.rd, s1_q.opcode};
      FMT_I_SH: pack_inst = {s1_q.funct7, s1_q.imm[4:0], s1_q.rs1, s1_q.funct3,
                             s1_q.rd, s1_q.opcode};
      FMT_S:    pack_inst = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                             s1_q.imm[4:0], s1_q.opcode};
      FMT_B:    pack_inst = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                             s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U:    pack_inst = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J:    pack_inst = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                             s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
      default:  pack_inst = '0;
    endcase
  end

  // Stage 1: field capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (in_hs) begin
        s1_vld <= 1'b1;
        s1_q   <= in_fields;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2: encoded word, address counter and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      INST      <= '0;
      IMM_ERR   <= 1'b0;
      ADDR      <= ADDR_W'(START_ADDR);
      ERR_SEEN  <= 1'b0;
    end else begin
      if (s1_adv) begin
        OUT_VALID <= 1'b1;
        INST      <= pack_inst;
        IMM_ERR   <= range_err;
      end else if (out_hs) begin
        OUT_VALID <= 1'b0;
      end
      // ADDR names the word currently on the output, so it only moves once
      // that word has been taken; wrap-around is intentional.
      if (out_hs) begin
        ADDR <= ADDR + ADDR_W'(1);
        if (IMM_ERR) begin
          ERR_SEEN <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int AW = 3;

  logic          CLK;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [2:0]    FMT;
  logic [6:0]    OPCODE;
  logic [4:0]    RD;
  logic [4:0]    RS1;
  logic [4:0]    RS2;
  logic [2:0]    FUNCT3;
  logic [6:0]    FUNCT7;
  logic [31:0]   IMM;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [31:0]   INST;
  logic [AW-1:0] ADDR;
  logic          IMM_ERR;
  logic          ERR_SEEN;

  inst_encoder #(.ADDR_W(AW), .START_ADDR(0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .FMT       (FMT),
    .OPCODE    (OPCODE),
    .RD        (RD),
    .RS1       (RS1),
    .RS2       (RS2),
    .FUNCT3    (FUNCT3),
    .FUNCT7    (FUNCT7),
    .IMM       (IMM),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .INST      (INST),
    .ADDR      (ADDR),
    .IMM_ERR   (IMM_ERR),
    .ERR_SEEN  (ERR_SEEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic [2:0] f, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (f)
      3'd0:       return 1'b0;
      3'd1, 3'd3: return !(v >= -2048 && v <= 2047);
      3'd2:       return !(v >= 0 && v <= 31);
      3'd4:       return !(v >= -4096 && v <= 4094 && (v % 2) == 0);
      3'd5:       return (imm % 4096) != 0;
      3'd6:       return !(v >= -1048576 && v <= 1048574 && (v % 2) == 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_enc(input logic [2:0] f, input int unsigned op,
      input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
      input int unsigned f3, input int unsigned f7, input int unsigned imm);
    int unsigned regs;
    regs = (rs1 << 15) | (f3 << 12);
    case (f)
      3'd0: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | op;
      3'd1: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | op;
      3'd2: return (f7 << 25) | ((imm & 31) << 20) | regs | (rd << 7) | op;
      3'd3: return (((imm >> 5) & 127) << 25) | (rs2 << 20) | regs | ((imm & 31) << 7) | op;
      3'd4: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | regs
                   | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
      3'd5: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      3'd6: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  // Control-path immediate generator, used to close the round trip.
  function automatic logic [31:0] immgen(input logic [2:0] f, input logic [31:0] i);
    case (f)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {27'b0, i[24:20]};
      3'd3:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd4:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd5:    return {i[31:12], 12'b0};
      3'd6:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    int          acc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] m_inst;
    logic        m_err;
    bit          has_lit;
    logic [31:0] lit_inst;
    logic        lit_err;
    int          lit_addr;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          exp_addr = 0;
  bit          exp_err_seen = 0;
  bit          started = 0;
  bit          cur_has_lit = 0;
  logic [31:0] cur_lit_inst = '0;
  logic        cur_lit_err = 1'b0;
  int          cur_lit_addr = -1;

  // One compare process: every cycle the DUT is checked against the
  // transaction queue. A word accepted at negedge-cycle c must be on the
  // output from cycle c+2 onwards until it is taken.
  always @(negedge CLK) begin : cmp
    bit   exp_vld;
    bit   s1_full;
    bit   exp_rdy;
    ent_t e;
    cyc++;
    if (started) begin
      exp_vld = (q.size() > 0) && (q[0].acc + 2 <= cyc);
      s1_full = (q.size() >= 2) || (q.size() == 1 && q[0].acc + 1 == cyc);
      exp_rdy = !s1_full || !exp_vld || OUT_READY;
      chk("out_valid", {31'b0, OUT_VALID}, {31'b0, exp_vld});
      chk("in_ready", {31'b0, IN_READY}, {31'b0, exp_rdy});
      chk("err_seen", {31'b0, ERR_SEEN}, {31'b0, exp_err_seen});
      if (exp_vld && OUT_VALID) begin
        e = q[0];
        chk("inst", INST, e.m_inst);
        chk("addr", {29'b0, ADDR}, exp_addr);
        chk("imm_err", {31'b0, IMM_ERR}, {31'b0, e.m_err});
        if (e.has_lit) begin
          chk("lit_inst", INST, e.lit_inst);
          chk("lit_imm_err", {31'b0, IMM_ERR}, {31'b0, e.lit_err});
          if (e.lit_addr >= 0) chk("lit_addr", {29'b0, ADDR}, e.lit_addr);
        end
        if (!e.m_err && e.fmt != 3'd0) chk("roundtrip_imm", immgen(e.fmt, INST), e.imm);
        if (OUT_READY) begin
          if (e.m_err) exp_err_seen = 1;
          exp_addr = (exp_addr + 1) % (1 << AW);
          void'(q.pop_front());
        end
      end
    end
    if (RST) begin
      q.delete();
      exp_addr = 0;
      exp_err_seen = 0;
      started = 1;
    end else if (started && IN_VALID && IN_READY) begin
      e.acc      = cyc;
      e.fmt      = FMT;
      e.imm      = IMM;
      e.m_inst   = m_enc(FMT, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM);
      e.m_err    = m_err(FMT, IMM);
      e.has_lit  = cur_has_lit;
      e.lit_inst = cur_lit_inst;
      e.lit_err  = cur_lit_err;
      e.lit_addr = cur_lit_addr;
      q.push_back(e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    FMT = f; OPCODE = op; RD = rd; RS1 = rs1; RS2 = rs2;
    FUNCT3 = f3; FUNCT7 = f7; IMM = imm;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm,
      input bit hl, input logic [31:0] li, input logic le, input int la);
    int n;
    n = 0;
    set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
    cur_has_lit = hl; cur_lit_inst = li; cur_lit_err = le; cur_lit_addr = la;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    cur_has_lit = 0;
  endtask

  function automatic logic [31:0] rand_imm(input logic [2:0] f);
    case (f)
      3'd1, 3'd3: return 32'(int'($urandom_range(0, 4095)) - 2048);
      3'd2:       return 32'($urandom_range(0, 31));
      3'd4:       return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      3'd5:       return $urandom & 32'hFFFFF000;
      3'd6:       return 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
      default:    return $urandom;
    endcase
  endfunction

  task automatic send_random();
    logic [2:0] f;
    f = 3'($urandom_range(0, 6));
    send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
         7'($urandom), rand_imm(f), 0, 32'h0, 1'b0, -1);
  endtask

  bit          rnd_bp;
  int          bp_acc;
  bit          hs;
  logic [31:0] held;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state.
    @(negedge CLK);
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_inst", INST, 32'h0);
    chk("rst_imm_err", {31'b0, IMM_ERR}, 32'd0);
    chk("rst_err_seen", {31'b0, ERR_SEEN}, 32'd0);
    chk("rst_addr", {29'b0, ADDR}, 32'd0);
    chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    @(posedge CLK); #1;

    // First word and its one-cycle latency.
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00093, 1'b0, 0);
    @(negedge CLK);
    chk("lat_in_s1", {31'b0, OUT_VALID}, 32'd0);
    @(negedge CLK);
    chk("lat_out_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("lat_inst", INST, 32'hFFF00093);
    @(posedge CLK); #1;

    // Directed words at full rate; addresses pinned, including the 7->0 wrap.
    send(FMT_S,    7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'd8,          1, 32'h0020A423, 1'b0, 1);
    send(FMT_B,    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    32'd8,          1, 32'h00208463, 1'b0, 2);
    send(FMT_U,    7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000,   1, 32'h123452B7, 1'b0, 3);
    send(FMT_R,    7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,    32'hDEADBEEF,   1, 32'h002081B3, 1'b0, 4);
    send(FMT_I_SH, 7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0,    32'd5,          1, 32'h00521193, 1'b0, 5);
    send(FMT_I_SH, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20,   32'd5,          1, 32'h40525193, 1'b0, 6);
    send(FMT_J,    7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd8,          1, 32'h008000EF, 1'b0, 7);
    send(FMT_B,    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    32'd3,          1, 32'h00208163, 1'b1, 0);
    send(FMT_I,    7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,       1, 32'h80000093, 1'b1, 1);
    send(3'd7,     7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,    32'd0,          1, 32'h00000000, 1'b1, 2);
    send(FMT_I_SH, 7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0,    32'd32,         1, 32'h00021193, 1'b1, 3);
    repeat (4) @(negedge CLK);
    chk("err_seen_sticky", {31'b0, ERR_SEEN}, 32'd1);
    @(posedge CLK); #1;

    // Back-pressure: consumer stalls for 5 cycles while input stays valid.
    OUT_READY = 1'b0;
    bp_acc = 0;
    set_fields(FMT_I, 7'h13, 5'd10, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
    IN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      hs = IN_READY;
      if (hs) bp_acc++;
      @(posedge CLK); #1;
      if (hs) set_fields(FMT_I, 7'h13, 5'(10 + bp_acc), 5'd2, 5'd0, 3'd0, 7'd0, 32'(100 + bp_acc));
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", bp_acc, 32'd2);
    @(negedge CLK);
    chk("bp_in_ready", {31'b0, IN_READY}, 32'd0);
    held = INST;
    repeat (2) @(negedge CLK);
    chk("bp_inst_stable", INST, held);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Round trip: random legal fields, all formats, full rate.
    for (int k = 0; k < 40; k++) send_random();

    // Same with a randomly stalling consumer.
    rnd_bp = 1;
    fork
      begin
        for (int k = 0; k < 20; k++) send_random();
        rnd_bp = 0;
      end
      begin
        while (rnd_bp) begin
          @(posedge CLK); #1;
          OUT_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Reset mid-burst with both stages full.
    OUT_READY = 1'b0;
    send(FMT_I, 7'h13, 5'd7, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 0, 32'h0, 1'b0, -1);
    send(FMT_I, 7'h13, 5'd8, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2, 0, 32'h0, 1'b0, -1);
    @(negedge CLK);
    chk("full_in_ready", {31'b0, IN_READY}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("midrst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("midrst_addr", {29'b0, ADDR}, 32'd0);
    chk("midrst_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("midrst_err_seen", {31'b0, ERR_SEEN}, 32'd0);
    @(posedge CLK); #1;
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00093, 1'b0, 0);
    repeat (4) @(posedge CLK);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32 instruction encoder: accepts decoded instruction fields plus a 32-bit immediate and produces the packed 32-bit instruction word. Each output carries an instruction-memory word address from an internal counter. It is the inverse of the control-path immediate generator and feeds the program loader and the self-checking benches. Two-stage valid/ready pipeline with back-pressure and immediate range checking.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `START_ADDR`, default 0: address of the first emitted word.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: input fields valid.
- `IN_READY` out 1: encoder accepts this cycle.
- `FMT` in 3: format selector, values from the shared package.
- `OPCODE` in 7: inst[6:0].
- `RD`, `RS1`, `RS2` in 5 each: register fields.
- `FUNCT3` in 3: inst[14:12].
- `FUNCT7` in 7: inst[31:25] for R and shift formats.
- `IMM` in 32: signed immediate, or shamt for shift format.
- `OUT_VALID` out 1: `INST`/`ADDR`/`IMM_ERR` valid.
- `OUT_READY` in 1: consumer accepts.
- `INST` out 32: encoded instruction.
- `ADDR` out `ADDR_W`: word address of `INST`.
- `IMM_ERR` out 1: `IMM` not representable in `FMT`.
- `ERR_SEEN` out 1: sticky OR of every emitted `IMM_ERR`.

## Operation
- Stage 1 (S1) registers the fields on each input handshake (`IN_VALID & IN_READY`).
- Stage 2 (OUT) holds the encoded word, computed from S1 when S1 advances.
- S1 advances when S1 is valid and (`OUT_VALID`=0 or `OUT_READY`=1).
- `IN_READY` is combinational: !S1_valid | S1_advance.
- Encoding per `FMT`:
  - R: {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}.
  - I: {IMM[11:0], RS1, FUNCT3, RD, OPCODE}.
  - I_SH: {FUNCT7, IMM[4:0], RS1, FUNCT3, RD, OPCODE}.
  - S: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - U: {IMM[31:12], RD, OPCODE}.
  - J: {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}.
- Range rules; violation sets `IMM_ERR`:
  - I and S: -2048..2047 (IMM[31:11] all equal).
  - I_SH: 0..31.
  - B: -4096..4094 and IMM[0]=0.
  - J: -2^20..2^20-2 and IMM[0]=0.
  - U: IMM[11:0]=0.
  - R: never flags an error.
  - Undefined `FMT` codes (7): `IMM_ERR`=1 and `INST`=0.
- On a range violation `INST` is still packed from the truncated bits listed above.
- Address counter:
  - `ADDR` holds the current output's address.
  - Increments by 1 on each output handshake.
  - Wraps modulo 2^`ADDR_W` silently.
- `ERR_SEEN` sets on an output handshake with `IMM_ERR`=1 and clears only on reset.

## Timing
- Reset values: `OUT_VALID`=0, `INST`=0, `IMM_ERR`=0, `ERR_SEEN`=0, `ADDR`=`START_ADDR`, S1 empty; hence `IN_READY`=1 in the first cycle after reset.
- Latency: input accepted at edge N → `OUT_VALID` at edge N+1 when OUT is free.
- Throughput: 1 word/cycle with `OUT_READY` held high.
- Back-pressure:
  - While `OUT_VALID`=1 and `OUT_READY`=0, OUT and `ADDR` hold stable.
  - S1 holds one more word; `IN_READY` then falls.
- At most 2 words are in flight.
- Simultaneous output handshake and S1 advance in one cycle: OUT reloads, `ADDR` increments, no bubble.
- Reset mid-stream: both stages are discarded and `ADDR` returns to `START_ADDR` at that edge regardless of handshakes.

## Structure
- Shared package (same file as the existing opcode/format constants): enum `fmt_t` = {FMT_R=0, FMT_I=1, FMT_I_SH=2, FMT_S=3, FMT_B=4, FMT_U=5, FMT_J=6}; range limit constants.
- Sub-module `imm_range_check`: combinational, (FMT, IMM) → error bit.
- Packing mux and pipeline/counter stay in `inst_encoder`.

## Test plan
- After reset: I, rd=1, rs1=0, f3=0, op=0x13, IMM=-1 → `INST`=0xFFF00093, `ADDR`=0, `IMM_ERR`=0, latency 1 cycle.
- S, op=0x23, f3=2, rs1=1, rs2=2, IMM=8 → `INST`=0x0020A423. B, op=0x63, f3=0, rs1=1, rs2=2, IMM=8 → `INST`=0x00208463. Addresses increment 0,1,2.
- U, op=0x37, rd=5, IMM=0x12345000 → `INST`=0x123452B7. B with IMM=3 → `IMM_ERR`=1 and `ERR_SEEN`=1 after the handshake. I with IMM=2048 → `IMM_ERR`=1.
- Back-pressure:
  - Stimulus: `OUT_READY`=0 for 5 cycles while `IN_VALID`=1.
  - Required: exactly 2 words accepted, `IN_READY`=0 after that, `OUT` stable.
  - On release: words emitted in order with no loss or duplication.
- Round trip:
  - Stimulus: random legal fields for all formats at full rate, `ADDR_W`=3.
  - Required: the immediate generator applied to `INST` returns `IMM`.
  - Required: `ADDR` wraps 7→0.
- Assert `RST` mid-burst with both stages full → next cycle `OUT_VALID`=0, `ADDR`=`START_ADDR`, `IN_READY`=1.
